register_file_2r1w: RTL and testbench

- 32 x 32-bit general-purpose register file: two registered read ports, one write port.
- Sits directly upstream of the processor's operand-select path; its register array feeds the 32-bit 32-to-1 read multiplexers, one per read port.
- Write-port row enables come from a 5-to-32 decoder.
- Register 0 is hardwired to zero.

---
 rtl/register_file_2r1w.sv | 82 ++++++++
 tb/tb_register_file_2r1w.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// 32 x 32-bit register file: two registered read ports, one write port,
// register 0 hardwired to zero, write-first bypass on read-during-write.
module register_file_2r1w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned REG_COUNT  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  R_VALID
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  wr_en_c;
    logic [DATA_WIDTH-1:0] rd1_c;
    logic [DATA_WIDTH-1:0] rd2_c;

    // One-hot row enable from the write address; row 0 never enabled.
    always_comb begin
        wr_en_c = '0;
        if (WRITE) begin
            wr_en_c[ADDR_W] = 1'b1;
        end
        wr_en_c[0] = 1'b0;
    end

    // Register 0 is a constant zero row.
    assign regs[0] = '0;

    // Storage rows 1..REG_COUNT-1.
    for (genvar g = 1; g < REG_COUNT; g++) begin : g_row
        always_ff @(posedge CLK) begin
            if (RST) begin
                regs[g] <= '0;
            end else if (wr_en_c[g]) begin
                regs[g] <= DATA_W;
            end
        end
    end

    // Read selection with per-port write-first bypass; address 0 forced to zero.
    always_comb begin
        rd1_c = regs[ADDR_R1];
        rd2_c = regs[ADDR_R2];
        if (WRITE && (ADDR_R1 == ADDR_W)) begin
            rd1_c = DATA_W;
        end
        if (WRITE && (ADDR_R2 == ADDR_W)) begin
            rd2_c = DATA_W;
        end
        if (ADDR_R1 == '0) begin
            rd1_c = '0;
        end
        if (ADDR_R2 == '0) begin
            rd2_c = '0;
        end
    end

    // Registered read ports; data holds when no read is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
            R_VALID <= 1'b0;
        end else begin
            R_VALID <= READ;
            if (READ) begin
                DATA_R1 <= rd1_c;
                DATA_R2 <= rd2_c;
            end
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w: driver pushes expected read data,
// monitor pops and compares whenever R_VALID is presented.
module tb_register_file_2r1w;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [4:0]  addr_r1;
    logic [4:0]  addr_r2;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] data_r1;
    logic [31:0] data_r2;
    logic        r_valid;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q [$];

    register_file_2r1w dut (
        .CLK     (clk),
        .RST     (rst),
        .READ    (read),
        .WRITE   (write),
        .ADDR_R1 (addr_r1),
        .ADDR_R2 (addr_r2),
        .ADDR_W  (addr_w),
        .DATA_W  (data_w),
        .DATA_R1 (data_r1),
        .DATA_R2 (data_r2),
        .R_VALID (r_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge; queue expected data for accepted reads.
    task automatic cyc(input logic r, input logic rd, input logic wr,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] aw, input logic [31:0] dw,
                       input logic [31:0] e1, input logic [31:0] e2);
        @(negedge clk);
        rst = r; read = rd; write = wr;
        addr_r1 = a1; addr_r2 = a2; addr_w = aw; data_w = dw;
        if (rd && !r) exp_q.push_back({e1, e2});
    endtask

    task automatic wr_reg(input logic [4:0] aw, input logic [31:0] dw);
        cyc(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, aw, dw, 32'h0, 32'h0);
    endtask

    task automatic rd_reg(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] e1, input logic [31:0] e2);
        cyc(1'b0, 1'b1, 1'b0, a1, a2, 5'd0, 32'h0, e1, e2);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: check R_VALID every cycle and compare popped data on each valid.
    initial begin : monitor
        logic        exp_v;
        logic [63:0] e;
        forever begin
            @(posedge clk);
            exp_v = read && !rst;
            #1;
            vectors++;
            if (r_valid !== exp_v) begin
                miscompares++;
                $display("FAIL r_valid @%0t: got %b expected %b", $time, r_valid, exp_v);
            end
            if (r_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid @%0t: got valid expected none", $time);
                end else begin
                    e = exp_q.pop_front();
                    check32("data_r1", data_r1, e[63:32]);
                    check32("data_r2", data_r2, e[31:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; read = 1'b0; write = 1'b0;
        addr_r1 = '0; addr_r2 = '0; addr_w = '0; data_w = '0;
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Reset clears state; strobes coincident with reset are lost.
        wr_reg(5'd5, 32'hDEADBEEF);
        rd_reg(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 5'd6, 32'h55555555, 32'h0, 32'h0);
        @(posedge clk); #2;
        check32("reset_data_r1", data_r1, 32'h0);
        check32("reset_data_r2", data_r2, 32'h0);
        rd_reg(5'd5, 5'd6, 32'h0, 32'h0);

        // Basic write then read.
        wr_reg(5'd7, 32'h12345678);
        rd_reg(5'd7, 5'd0, 32'h12345678, 32'h0);

        // Register 0 hardwired, including the bypass path.
        wr_reg(5'd0, 32'hFFFFFFFF);
        rd_reg(5'd0, 5'd0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);

        // Write-first bypass, both ports and per-port independent.
        wr_reg(5'd9, 32'h1111);
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'h2222, 32'h2222, 32'h2222);
        rd_reg(5'd9, 5'd4, 32'h2222, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 5'd10, 5'd9, 5'd10, 32'h00000ABC, 32'h00000ABC, 32'h2222);
        rd_reg(5'd9, 5'd10, 32'h2222, 32'h00000ABC);

        // Hold: outputs stay while READ=0 and the source register changes.
        wr_reg(5'd3, 32'hA5A5A5A5);
        rd_reg(5'd3, 5'd7, 32'hA5A5A5A5, 32'h12345678);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0);
            @(posedge clk); #2;
            check32("hold_data_r1", data_r1, 32'hA5A5A5A5);
            check32("hold_data_r2", data_r2, 32'h12345678);
        end
        rd_reg(5'd3, 5'd3, 32'h0, 32'h0);

        // Full sweep: write 1..31, then back-to-back pair reads.
        for (int i = 1; i < 32; i++) begin
            wr_reg(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            rd_reg(5'(i), 5'(31 - i), 32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101);
        end
        idle();
        idle();
        idle();
        @(posedge clk); #2;

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
